// File: rtl/chk_pkg.sv
// Shared types and default parameter values for the stream checker.
package chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } chk_state_t;

    localparam int DEF_WIDTH         = 1;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_FAIL_FAST     = 0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/dff_stream_checker.sv
// Compares a DUT output against an expected pattern over a start/stop window,
// counting mismatches and capturing the first one.
module dff_stream_checker
    import chk_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int FAIL_FAST     = DEF_FAIL_FAST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] test,
    input  logic [WIDTH-1:0] pat,
    input  logic [WIDTH-1:0] mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cyc_count,
    output logic [CNT_W-1:0] first_err_cyc,
    output logic [WIDTH-1:0] first_err_test,
    output logic [WIDTH-1:0] first_err_pat
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;

    chk_state_t    state;
    logic [SW-1:0] settle_cnt;
    logic          mism;
    logic          arm;
    logic          compare;
    logic          first_hit;

    // Case inequality lets an X/Z on a masked-in bit register as a mismatch.
    assign mism      = ((test & mask) !== (pat & mask));
    assign arm       = start && ((state == IDLE) || (state == DONE));
    assign compare   = (state == CHECK) && !stop;
    assign first_hit = compare && mism && (err_count == '0);
    assign pass      = done && (err_count == '0);

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (arm),
        .inc   (compare),
        .value (cyc_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (arm),
        .inc   (compare && mism),
        .value (err_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            first_err_cyc  <= '0;
            first_err_test <= '0;
            first_err_pat  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        first_err_cyc  <= '0;
                        first_err_test <= '0;
                        first_err_pat  <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        if (SETTLE_CYCLES == 0) begin
                            state <= CHECK;
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    if (stop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (settle_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (stop || ((FAIL_FAST != 0) && mism)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    // The capture uses cyc_count before this cycle's increment.
                    if (first_hit) begin
                        first_err_cyc  <= cyc_count;
                        first_err_test <= test;
                        first_err_pat  <= pat;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
